// File: rtl/wall_drawer.sv
// Wall sprite redraw engine: optionally erases the previous wall column, then
// draws the current one with its gap, emitting one registered pixel per cycle.
module wall_drawer #(
  parameter int unsigned WALL_WIDTH  = 8,
  parameter int unsigned WALL_HEIGHT = 120,
  parameter int unsigned HOLE_HEIGHT = 50,
  parameter int unsigned SCREEN_W    = 160,
  parameter logic [2:0]  WALL_COLOUR = 3'b010,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] wall_x,
  input  logic [7:0] hole_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CXW = (WALL_WIDTH  > 1) ? $clog2(WALL_WIDTH)  : 1;
  localparam int unsigned CYW = (WALL_HEIGHT > 1) ? $clog2(WALL_HEIGHT) : 1;
  localparam logic [CXW-1:0] CX_LAST = CXW'(WALL_WIDTH - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(WALL_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [CXW-1:0] cx, cx_n;
  logic [CYW-1:0] cy, cy_n;
  logic [7:0]     cur_x, cur_x_n;
  logic [7:0]     cur_hole, cur_hole_n;
  logic [7:0]     prev_x, prev_x_n;
  logic           prev_valid, prev_valid_n;

  logic       scan_n;
  logic [7:0] base_n;
  logic [8:0] sum_n;
  logic [8:0] cy9_n;
  logic [8:0] hole_end_n;
  logic       in_hole_n;
  logic [7:0] vga_x_n;
  logic [6:0] vga_y_n;
  logic [2:0] colour_n;
  logic       plot_n;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n      = state;
    cx_n         = cx;
    cy_n         = cy;
    cur_x_n      = cur_x;
    cur_hole_n   = cur_hole;
    prev_x_n     = prev_x;
    prev_valid_n = prev_valid;

    unique case (state)
      IDLE: begin
        if (start) begin
          cur_x_n    = wall_x;
          cur_hole_n = hole_y;
          cx_n       = '0;
          cy_n       = '0;
          state_n    = prev_valid ? ERASE : DRAW;
        end
      end
      ERASE, DRAW: begin
        if (cx == CX_LAST && cy == CY_LAST) begin
          cx_n    = '0;
          cy_n    = '0;
          state_n = (state == ERASE) ? DRAW : DONE;
        end else if (cx == CX_LAST) begin
          cx_n = '0;
          cy_n = cy + 1'b1;
        end else begin
          cx_n = cx + 1'b1;
        end
      end
      DONE: begin
        prev_x_n     = cur_x;
        prev_valid_n = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pixel outputs are computed from the next-state values so they can be
  // registered without adding a cycle of latency after start.
  always_comb begin
    scan_n     = (state_n == ERASE) || (state_n == DRAW);
    base_n     = (state_n == ERASE) ? prev_x : cur_x_n;
    sum_n      = {1'b0, base_n} + 9'(cx_n);
    cy9_n      = 9'(cy_n);
    hole_end_n = {1'b0, cur_hole_n} + 9'(HOLE_HEIGHT);
    in_hole_n  = (cy9_n >= {1'b0, cur_hole_n}) && (cy9_n < hole_end_n);
    plot_n     = scan_n && (sum_n < 9'(SCREEN_W));
    vga_x_n    = '0;
    vga_y_n    = '0;
    colour_n   = '0;
    if (scan_n) begin
      vga_x_n  = sum_n[7:0];
      vga_y_n  = 7'(cy_n);
      colour_n = (state_n == DRAW && !in_hole_n) ? WALL_COLOUR : BG_COLOUR;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cx         <= '0;
      cy         <= '0;
      cur_x      <= '0;
      cur_hole   <= '0;
      prev_x     <= '0;
      prev_valid <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cx         <= cx_n;
      cy         <= cy_n;
      cur_x      <= cur_x_n;
      cur_hole   <= cur_hole_n;
      prev_x     <= prev_x_n;
      prev_valid <= prev_valid_n;
      vga_x      <= vga_x_n;
      vga_y      <= vga_y_n;
      colour     <= colour_n;
      plot       <= plot_n;
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_wall_drawer.sv
// Scoreboard bench for wall_drawer: expected pixels are queued from a model
// when start is driven and popped as the DUT plots them.
module tb_wall_drawer;

  localparam int W = 8;
  localparam int H = 120;
  localparam int HOLE = 50;
  localparam int SW = 160;
  localparam int N = W * H;
  localparam logic [2:0] WALL_C = 3'b010;
  localparam logic [2:0] BG_C   = 3'b000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] wall_x;
  logic [7:0] hole_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t sb[$];
  int   tests_run = 0;
  int   fails = 0;

  wall_drawer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .wall_x(wall_x),
    .hole_y(hole_y),
    .vga_x (vga_x),
    .vga_y (vga_y),
    .colour(colour),
    .plot  (plot),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rect(input int base, input bit erase, input int hole);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (base + x < SW) begin
          pix_t p;
          p.x = 8'(base + x);
          p.y = 7'(y);
          if (erase) p.c = BG_C;
          else p.c = (y >= hole && y < hole + HOLE) ? BG_C : WALL_C;
          sb.push_back(p);
        end
      end
    end
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_plot", 32'(plot), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
  endtask

  // mode 0: one-cycle start; 1: start held until done; 2: extra start pulse in
  // the DONE cycle; 3: reset after abort_at plots.
  task automatic redraw(input int wx, input int hy, input bit has_erase, input int px,
                        input int mode, input int abort_at);
    int cyc;
    int plots;
    int exp_plots;
    int exp_done;
    bit seen_done;
    pix_t got;
    pix_t exp;
    sb.delete();
    if (has_erase) push_rect(px, 1'b1, 0);
    push_rect(wx, 1'b0, hy);
    exp_plots = sb.size();
    exp_done  = has_erase ? (1 + N + N + 1) : (1 + N + 1);
    plots     = 0;
    seen_done = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    wall_x = 8'(wx);
    hole_y = 8'(hy);
    cyc    = 1;
    while (!seen_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (mode != 1) start = 1'b0;
      wall_x = 8'($urandom);
      hole_y = 8'($urandom);
      if (cyc == 2) chk("busy_first", 32'(busy), 32'd1);
      if (plot) begin
        plots++;
        got = '{x: vga_x, y: vga_y, c: colour};
        if (sb.size() == 0) begin
          chk("extra_plot", 32'(got), 32'h3ffff);
        end else begin
          exp = sb.pop_front();
          chk("pixel", 32'(got), 32'(exp));
        end
      end
      if (mode == 3 && plots == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_plot", 32'(plot), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        return;
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_cycle", 32'(cyc), 32'(exp_done));
        chk("plot_count", 32'(plots), 32'(exp_plots));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        start = (mode == 2);
      end
    end
    if (!seen_done) chk("done_timeout", 32'(cyc), 32'(exp_done));
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd0);
    idle_check(4);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    wall_x = '0;
    hole_y = '0;
    #12;
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_xyc", 32'({vga_x, vga_y, colour}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_check(2);

    redraw(100, 60, 1'b0, 0, 0, 0);     // first draw, no erase
    redraw(99, 60, 1'b1, 100, 0, 0);    // erase then draw

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    redraw(156, 60, 1'b0, 0, 0, 0);     // clipped first draw
    redraw(30, 100, 1'b1, 156, 0, 0);   // clipped erase, hole at bottom edge
    redraw(40, 0, 1'b1, 30, 1, 0);      // start held high
    redraw(50, 71, 1'b1, 40, 2, 0);     // start pulse in DONE cycle
    redraw(20, 10, 1'b1, 50, 3, 960 + 300); // reset at DRAW pixel 300
    idle_check(2);
    redraw(60, 5, 1'b0, 0, 0, 0);       // no erase after reset

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
